// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi
//   Multi-channel PWM LED driver. One shared free-running counter feeds
//   CHANNELS comparators. Each channel has a runtime-programmable mode
//   (off, static, triangle breathe, blink), a level and a step rate.
//
// Parameters
//   WIDTH     PWM/duty resolution in bits (period = 2^WIDTH clocks)
//   CHANNELS  number of PWM outputs (1..8)
//   RATE_W    width of the per-channel step-rate field
//
// Ports
//   clk          system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   enable       global output enable, gates pwm_out only
//   cfg_we       one-cycle configuration write strobe
//   cfg_ch       target channel; codes >= CHANNELS are ignored
//   cfg_mode     00 OFF, 01 STATIC, 10 BREATHE, 11 BLINK
//   cfg_level    peak/static duty
//   cfg_rate     periods per envelope step, minus one
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-clock pulse aligned with counter value 0
module pwm_breathe_multi #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4,
  parameter int RATE_W   = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_level,
  input  logic [RATE_W-1:0]   cfg_rate,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  logic [WIDTH-1:0]    cnt;
  logic                boundary;
  logic                cfg_valid;

  mode_t               mode_q   [CHANNELS];
  logic [WIDTH-1:0]    level_q  [CHANNELS];
  logic [RATE_W-1:0]   rate_q   [CHANNELS];
  logic [WIDTH-1:0]    env_q    [CHANNELS];
  logic [RATE_W-1:0]   presc_q  [CHANNELS];
  logic [WIDTH-1:0]    shd_q    [CHANNELS];
  logic [WIDTH-1:0]    duty_src [CHANNELS];
  logic [CHANNELS-1:0] dir_q;
  logic [CHANNELS-1:0] ph_q;

  // The last count of a period is the edge where shadows load and
  // envelopes step.
  assign boundary = (cnt == {WIDTH{1'b1}});

  // Channel codes beyond the implemented range are dropped so that a
  // non-power-of-two build never aliases onto a real channel.
  assign cfg_valid = cfg_we && (32'(cfg_ch) < 32'(CHANNELS));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_src[i] = '0;
      case (mode_q[i])
        MODE_STATIC:  duty_src[i] = level_q[i];
        MODE_BREATHE: duty_src[i] = env_q[i];
        MODE_BLINK:   duty_src[i] = ph_q[i] ? level_q[i] : '0;
        default:      duty_src[i] = '0;
      endcase
    end
  end

  // Comparing against the shadow (not the live duty source) keeps every
  // period glitch-free; the compare result is registered, so pwm_out lags
  // cnt by one clock and is always low in the cycle where cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_tick <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable & (cnt < shd_q[i]);
      end
    end
  end

  // A config write takes priority over an envelope step on the same edge,
  // but the shadow still captures the pre-write duty source at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        level_q[i] <= '0;
        rate_q[i]  <= '0;
        env_q[i]   <= '0;
        presc_q[i] <= '0;
        shd_q[i]   <= '0;
        dir_q[i]   <= 1'b1;
        ph_q[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) begin
          shd_q[i] <= duty_src[i];
        end

        if (cfg_valid && (cfg_ch == CH_W'(i))) begin
          mode_q[i]  <= mode_t'(cfg_mode);
          level_q[i] <= cfg_level;
          rate_q[i]  <= cfg_rate;
          env_q[i]   <= '0;
          presc_q[i] <= '0;
          dir_q[i]   <= 1'b1;
          ph_q[i]    <= 1'b0;
        end else if (boundary &&
                     (mode_q[i] == MODE_BREATHE || mode_q[i] == MODE_BLINK)) begin
          if (presc_q[i] == rate_q[i]) begin
            presc_q[i] <= '0;
            if (mode_q[i] == MODE_BREATHE) begin
              // Turning at the peak already moves one step down, and turning
              // at zero already moves one step up, so each end value is held
              // for a single step and the cycle is exactly 2*level steps.
              if (dir_q[i]) begin
                if (env_q[i] >= level_q[i]) begin
                  dir_q[i] <= 1'b0;
                  env_q[i] <= (env_q[i] == '0) ? '0 : env_q[i] - 1'b1;
                end else begin
                  env_q[i] <= env_q[i] + 1'b1;
                end
              end else begin
                if (env_q[i] == '0) begin
                  dir_q[i] <= 1'b1;
                  env_q[i] <= WIDTH'(level_q[i] != '0);
                end else begin
                  env_q[i] <= env_q[i] - 1'b1;
                end
              end
            end else begin
              ph_q[i] <= ~ph_q[i];
            end
          end else begin
            presc_q[i] <= presc_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi
//   Self-checking bench for pwm_breathe_multi. Five channels are built so
//   that cfg_ch has spare codes (5..7) which must be ignored.
module tb_pwm_breathe_multi;

  localparam int W      = 6;
  localparam int NCH    = 5;
  localparam int RW     = 8;
  localparam int CHW    = 3;
  localparam int PERIOD = 64;

  localparam int M_OFF     = 0;
  localparam int M_STATIC  = 1;
  localparam int M_BREATHE = 2;
  localparam int M_BLINK   = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b1;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [W-1:0]   cfg_level = '0;
  logic [RW-1:0]  cfg_rate = '0;
  logic [NCH-1:0] pwm_out;
  logic           period_tick;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: per-channel parameters plus the number of period
  // boundaries since the last write.
  int m_mode  [NCH];
  int m_level [NCH];
  int m_rate  [NCH];
  int m_b     [NCH];

  // Pending write for the next period: 0 none, 1 at its start, 2 at its end.
  int wr_pending = 0;
  int wr_ch, wr_mode, wr_level, wr_rate;
  bit en_next = 1'b1;

  bit def_valid = 1'b0;
  int def_ch, def_mode, def_level, def_rate;

  int ticks_seen = 0;

  pwm_breathe_multi #(
    .WIDTH    (W),
    .CHANNELS (NCH),
    .RATE_W   (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_level   (cfg_level),
    .cfg_rate    (cfg_rate),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Duty of the period whose shadow loaded at boundary b after a write.
  // s envelope steps have elapsed before that boundary.
  function automatic int model_duty(input int mode, input int level,
                                    input int rate, input int b);
    int s;
    int t;
    int bb;
    bb = (b < 1) ? 1 : b;
    s = (bb - 1) / (rate + 1);
    case (mode)
      M_STATIC:  model_duty = level;
      M_BREATHE: begin
        if (level == 0) begin
          model_duty = 0;
        end else begin
          t = s % (2 * level);
          model_duty = (t <= level) ? t : (2 * level - t);
        end
      end
      M_BLINK:   model_duty = ((s % 2) == 1) ? level : 0;
      default:   model_duty = 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c]  = M_OFF;
      m_level[c] = 0;
      m_rate[c]  = 0;
      m_b[c]     = 0;
    end
    wr_pending = 0;
    def_valid  = 1'b0;
  endtask

  task automatic model_write(input int ch, input int mode, input int level,
                             input int rate);
    if (ch < NCH) begin
      m_mode[ch]  = mode;
      m_level[ch] = level;
      m_rate[ch]  = rate;
      m_b[ch]     = 0;
    end
  endtask

  task automatic applyStimulus(input int when, input int ch, input int mode,
                               input int level, input int rate);
    wr_pending = when;
    wr_ch      = ch;
    wr_mode    = mode;
    wr_level   = level;
    wr_rate    = rate;
  endtask

  task automatic drive_cfg();
    logic [31:0] v;
    cfg_we    = 1'b1;
    v = wr_ch;    cfg_ch    = v[CHW-1:0];
    v = wr_mode;  cfg_mode  = v[1:0];
    v = wr_level; cfg_level = v[W-1:0];
    v = wr_rate;  cfg_rate  = v[RW-1:0];
  endtask

  // Runs one full period starting at the negedge where period_tick is high,
  // counting high clocks per channel and checking them against the model.
  task automatic run_period(input string name, input bit back_to_back);
    int waited;
    int hi    [NCH];
    int rises [NCH];
    int expd  [NCH];
    int tick_hits;
    logic [NCH-1:0] prev;

    waited = 0;
    while (period_tick !== 1'b1 && waited < 3 * PERIOD) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (period_tick !== 1'b1 || (back_to_back && waited != 0)) begin
      $display("[TB] FAIL %s tick_spacing: waited %0d clocks (tick=%b), required %0d",
               name, waited, period_tick, back_to_back ? 0 : waited);
      tests_failed++;
      if (period_tick !== 1'b1) begin
        cfg_we = 1'b0;
        return;
      end
    end

    enable = en_next;
    for (int c = 0; c < NCH; c++) begin
      m_b[c]++;
      expd[c]  = en_next ? model_duty(m_mode[c], m_level[c], m_rate[c], m_b[c]) : 0;
      hi[c]    = 0;
      rises[c] = 0;
    end
    prev = '0;
    tick_hits = 0;

    for (int k = 0; k < PERIOD; k++) begin
      if (k == 0 && wr_pending == 1) drive_cfg();
      if (k == 1) cfg_we = 1'b0;
      if (period_tick === 1'b1) tick_hits++;
      for (int c = 0; c < NCH; c++) begin
        if (pwm_out[c] === 1'b1) begin
          hi[c]++;
          if (prev[c] !== 1'b1) rises[c]++;
        end
      end
      prev = pwm_out;
      if (k == PERIOD - 1 && wr_pending == 2) drive_cfg();
      @(negedge clk);
    end
    cfg_we = 1'b0;

    for (int c = 0; c < NCH; c++) begin
      tests_run++;
      if (hi[c] !== expd[c] || rises[c] !== ((expd[c] != 0) ? 1 : 0)) begin
        $display("[TB] FAIL %s ch%0d duty: got %0d high clocks in %0d runs, required %0d in one run",
                 name, c, hi[c], rises[c], expd[c]);
        tests_failed++;
      end
    end
    tests_run++;
    if (tick_hits !== 1) begin
      $display("[TB] FAIL %s tick_width: got %0d tick clocks, required 1", name, tick_hits);
      tests_failed++;
    end
    ticks_seen += tick_hits;

    if (def_valid) begin
      model_write(def_ch, def_mode, def_level, def_rate);
      def_valid = 1'b0;
    end
    if (wr_pending == 1) begin
      model_write(wr_ch, wr_mode, wr_level, wr_rate);
    end else if (wr_pending == 2) begin
      def_valid = 1'b1;
      def_ch    = wr_ch;
      def_mode  = wr_mode;
      def_level = wr_level;
      def_rate  = wr_rate;
    end
    wr_pending = 0;
  endtask

  // After reset release the counter starts at 0, so the first tick is 64
  // clocks later.
  task automatic wait_first_tick(input string name);
    int waited;
    waited = 0;
    while (period_tick !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (waited !== PERIOD || period_tick !== 1'b1) begin
      $display("[TB] FAIL %s first_tick: got %0d clocks, required %0d", name, waited, PERIOD);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pwm_out !== '0) begin
      $display("[TB] FAIL reset pwm_out: got %b, required 0", pwm_out);
      tests_failed++;
    end
    tests_run++;
    if (period_tick !== 1'b0) begin
      $display("[TB] FAIL reset period_tick: got %b, required 0", period_tick);
      tests_failed++;
    end
    rst_n = 1'b1;
    model_reset();
    wait_first_tick("reset");
    run_period("reset_idle", 1'b1);
  endtask

  task automatic test_static();
    applyStimulus(1, 0, M_STATIC, 16, 0);
    repeat (4) run_period("static16", 1'b1);
    applyStimulus(1, 0, M_STATIC, 63, 0);
    repeat (3) run_period("static63", 1'b1);
    applyStimulus(1, 0, M_STATIC, 0, 0);
    repeat (2) run_period("static0", 1'b1);
  endtask

  task automatic test_breathe();
    applyStimulus(1, 1, M_BREATHE, 4, 0);
    repeat (20) run_period("breathe4", 1'b1);
  endtask

  task automatic test_blink();
    int start_ticks;
    applyStimulus(1, 2, M_BLINK, 32, 2);
    start_ticks = ticks_seen;
    repeat (13) run_period("blink32", 1'b1);
    tests_run++;
    if (ticks_seen - start_ticks !== 13) begin
      $display("[TB] FAIL blink tick_count: got %0d, required 13", ticks_seen - start_ticks);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 1, M_STATIC, 20, 0);
    repeat (2) run_period("b2b_pre", 1'b1);
    applyStimulus(2, 1, M_STATIC, 50, 0);
    repeat (3) run_period("b2b_static", 1'b1);
    applyStimulus(2, 1, M_BREATHE, 3, 1);
    repeat (6) run_period("b2b_breathe", 1'b1);
    applyStimulus(1, 7, M_STATIC, 40, 0);
    repeat (3) run_period("invalid_ch", 1'b1);
  endtask

  task automatic test_enable();
    applyStimulus(1, 1, M_BREATHE, 10, 0);
    run_period("en_cfg1", 1'b1);
    applyStimulus(1, 4, M_STATIC, 63, 0);
    repeat (3) run_period("en_on", 1'b1);
    en_next = 1'b0;
    repeat (4) run_period("en_off", 1'b1);
    en_next = 1'b1;
    repeat (4) run_period("en_back", 1'b1);
  endtask

  task automatic test_async_reset();
    repeat (10) @(posedge clk);
    #2;
    tests_run++;
    if (pwm_out[4] !== 1'b1) begin
      $display("[TB] FAIL async_pre ch4: got %b, required 1", pwm_out[4]);
      tests_failed++;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pwm_out !== '0 || period_tick !== 1'b0) begin
      $display("[TB] FAIL async_reset outputs: got pwm=%b tick=%b, required 0", pwm_out, period_tick);
      tests_failed++;
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (pwm_out !== '0) begin
      $display("[TB] FAIL async_hold pwm_out: got %b, required 0", pwm_out);
      tests_failed++;
    end
    rst_n = 1'b1;
    model_reset();
    wait_first_tick("async");
    repeat (2) run_period("after_reset", 1'b1);
    applyStimulus(1, 3, M_BLINK, 9, 0);
    repeat (4) run_period("after_reset_cfg", 1'b1);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 5);
      if (r < 2) begin
        applyStimulus(r + 1, $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 63), $urandom_range(0, 2));
      end
      en_next = ($urandom_range(0, 4) != 0);
      run_period("random", 1'b1);
    end
    en_next = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_static();
    test_breathe();
    test_blink();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
